hier_icache_maint_seq: RTL and testbench

HIER_ICACHE_MAINT_SEQ -- requirements
Module: hier_icache_maint_seq

---
 rtl/hier_icache_pkg.sv | 37 +++
 rtl/hier_icache_maint_seq_if.sv | 51 +++++
 rtl/hier_icache_ack_collector.sv | 26 ++
 rtl/hier_icache_maint_seq.sv | 151 +++++++++++++++
 tb/tb_hier_icache_maint_seq.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/hier_icache_pkg.sv
// Shared types for the hierarchical icache maintenance sequencer.
package hier_icache_pkg;

   localparam int unsigned OP_W   = 3;
   localparam int unsigned ADDR_W = 32;

   typedef enum logic [OP_W-1:0] {
      FLUSH     = 3'd0,
      SEL_FLUSH = 3'd1,
      ENABLE    = 3'd2,
      DISABLE   = 3'd3
   } cmd_op_e;

   typedef enum logic [1:0] {
      IDLE,
      L1_PHASE,
      L2_PHASE,
      DONE
   } state_e;

   // Captured command payload, held from grant until the next grant.
   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [ADDR_W-1:0] addr;
   } cmd_t;

   // Opcodes outside the enum complete immediately with an error.
   function automatic logic op_is_legal(input logic [OP_W-1:0] op);
      return op <= OP_W'(DISABLE);
   endfunction

   // Flush-type ops touch the private L1s before the shared L2.
   function automatic logic op_uses_l1(input logic [OP_W-1:0] op);
      return (op == OP_W'(FLUSH)) || (op == OP_W'(SEL_FLUSH));
   endfunction

endpackage

// File: rtl/hier_icache_maint_seq_if.sv
// Command and per-cache request/ack bundle of the maintenance sequencer.
interface hier_icache_maint_seq_if #(
   parameter int unsigned NB_CORES       = 9,
   parameter int unsigned NB_CACHE_BANKS = 4
);
   logic                      cmd_req_i;
   logic [2:0]                cmd_op_i;
   logic [31:0]               cmd_addr_i;
   logic                      cmd_gnt_o;
   logic                      done_valid_o;
   logic                      done_err_o;
   logic                      busy_o;

   logic [NB_CORES-1:0]       l1_flush_req_o;
   logic [NB_CORES-1:0]       l1_sel_flush_req_o;
   logic [NB_CORES-1:0]       l1_flush_ack_i;
   logic [NB_CORES-1:0]       l1_sel_flush_ack_i;
   logic [31:0]               l1_sel_flush_addr_o;

   logic [NB_CACHE_BANKS-1:0] l2_flush_req_o;
   logic [NB_CACHE_BANKS-1:0] l2_sel_flush_req_o;
   logic [NB_CACHE_BANKS-1:0] l2_enable_req_o;
   logic [NB_CACHE_BANKS-1:0] l2_disable_req_o;
   logic [NB_CACHE_BANKS-1:0] l2_flush_ack_i;
   logic [NB_CACHE_BANKS-1:0] l2_sel_flush_ack_i;
   logic [NB_CACHE_BANKS-1:0] l2_enable_ack_i;
   logic [NB_CACHE_BANKS-1:0] l2_disable_ack_i;
   logic [31:0]               l2_sel_flush_addr_o;

   // Sequencer side.
   modport master (
      input  cmd_req_i, cmd_op_i, cmd_addr_i,
      output cmd_gnt_o, done_valid_o, done_err_o, busy_o,
      output l1_flush_req_o, l1_sel_flush_req_o, l1_sel_flush_addr_o,
      input  l1_flush_ack_i, l1_sel_flush_ack_i,
      output l2_flush_req_o, l2_sel_flush_req_o, l2_enable_req_o, l2_disable_req_o,
      output l2_sel_flush_addr_o,
      input  l2_flush_ack_i, l2_sel_flush_ack_i, l2_enable_ack_i, l2_disable_ack_i
   );

   // Command issuer and cache side.
   modport slave (
      output cmd_req_i, cmd_op_i, cmd_addr_i,
      input  cmd_gnt_o, done_valid_o, done_err_o, busy_o,
      input  l1_flush_req_o, l1_sel_flush_req_o, l1_sel_flush_addr_o,
      output l1_flush_ack_i, l1_sel_flush_ack_i,
      input  l2_flush_req_o, l2_sel_flush_req_o, l2_enable_req_o, l2_disable_req_o,
      input  l2_sel_flush_addr_o,
      output l2_flush_ack_i, l2_sel_flush_ack_i, l2_enable_ack_i, l2_disable_ack_i
   );
endinterface

// File: rtl/hier_icache_ack_collector.sv
// Pending-request mask for one cache level: loaded all-ones, bits retire on req&ack.
module hier_icache_ack_collector #(
   parameter int unsigned N = 1
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         i_load,
   input  logic         i_clear,
   input  logic         i_en,
   input  logic [N-1:0] i_ack,
   output logic [N-1:0] o_req,
   output logic         o_all_done
);
   logic [N-1:0] r_pend;

   assign o_req      = i_en ? r_pend : '0;
   assign o_all_done = ((r_pend & ~i_ack) == '0);

   // Pending mask: load wins over clear, otherwise retire acked requests.
   always_ff @(posedge clk_i) begin
      if (!rst_ni)      r_pend <= '0;
      else if (i_load)  r_pend <= '1;
      else if (i_clear) r_pend <= '0;
      else              r_pend <= r_pend & ~(o_req & i_ack);
   end
endmodule

// File: rtl/hier_icache_maint_seq.sv
// Sequences flush/enable/disable maintenance across private L1 and shared L2 icaches.
module hier_icache_maint_seq
   import hier_icache_pkg::*;
#(
   parameter int unsigned NB_CORES       = 9,
   parameter int unsigned NB_CACHE_BANKS = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input logic                   clk_i,
   input logic                   rst_ni,
   hier_icache_maint_seq_if.master bus
);
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_e                    r_state, w_state_nxt;
   cmd_t                      r_cmd, w_cmd_nxt;
   logic                      r_err, w_err_nxt;
   logic [CNT_W-1:0]          r_cnt, w_cnt_nxt;
   logic                      w_gnt, w_l1_load, w_l2_load, w_clear, w_timeout;
   logic                      w_l1_done, w_l2_done;
   logic [NB_CORES-1:0]       w_l1_ack, w_l1_req;
   logic [NB_CACHE_BANKS-1:0] w_l2_ack, w_l2_req;

   assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);

   // Route the ack vector belonging to the captured op into each collector.
   always_comb begin
      w_l1_ack = (r_cmd.op == OP_W'(SEL_FLUSH)) ? bus.l1_sel_flush_ack_i : bus.l1_flush_ack_i;
      w_l2_ack = '0;
      case (r_cmd.op)
         OP_W'(FLUSH):     w_l2_ack = bus.l2_flush_ack_i;
         OP_W'(SEL_FLUSH): w_l2_ack = bus.l2_sel_flush_ack_i;
         OP_W'(ENABLE):    w_l2_ack = bus.l2_enable_ack_i;
         OP_W'(DISABLE):   w_l2_ack = bus.l2_disable_ack_i;
         default:          w_l2_ack = '0;
      endcase
   end

   hier_icache_ack_collector #(.N(NB_CORES)) u_l1_coll (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .i_load     (w_l1_load),
      .i_clear    (w_clear),
      .i_en       (r_state == L1_PHASE),
      .i_ack      (w_l1_ack),
      .o_req      (w_l1_req),
      .o_all_done (w_l1_done)
   );

   hier_icache_ack_collector #(.N(NB_CACHE_BANKS)) u_l2_coll (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .i_load     (w_l2_load),
      .i_clear    (w_clear),
      .i_en       (r_state == L2_PHASE),
      .i_ack      (w_l2_ack),
      .o_req      (w_l2_req),
      .o_all_done (w_l2_done)
   );

   // State, captured command, error flag and phase timer.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state <= IDLE;
         r_cmd   <= '0;
         r_err   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cmd   <= w_cmd_nxt;
         r_err   <= w_err_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state: grant in IDLE, phase completion beats timeout, DONE lasts one cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_cmd_nxt   = r_cmd;
      w_err_nxt   = r_err;
      w_cnt_nxt   = r_cnt;
      w_gnt       = 1'b0;
      w_l1_load   = 1'b0;
      w_l2_load   = 1'b0;
      w_clear     = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.cmd_req_i) begin
               w_gnt          = 1'b1;
               w_cmd_nxt.op   = bus.cmd_op_i;
               w_cmd_nxt.addr = bus.cmd_addr_i;
               w_cnt_nxt      = '0;
               w_err_nxt      = 1'b0;
               if (!op_is_legal(bus.cmd_op_i)) begin
                  w_state_nxt = DONE;
                  w_err_nxt   = 1'b1;
               end else if (op_uses_l1(bus.cmd_op_i)) begin
                  w_state_nxt = L1_PHASE;
                  w_l1_load   = 1'b1;
               end else begin
                  w_state_nxt = L2_PHASE;
                  w_l2_load   = 1'b1;
               end
            end
         end
         L1_PHASE: begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
            if (w_l1_done) begin
               w_state_nxt = L2_PHASE;
               w_l2_load   = 1'b1;
               w_cnt_nxt   = '0;
            end else if (w_timeout) begin
               w_state_nxt = DONE;
               w_clear     = 1'b1;
               w_err_nxt   = 1'b1;
            end
         end
         L2_PHASE: begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
            if (w_l2_done) begin
               w_state_nxt = DONE;
            end else if (w_timeout) begin
               w_state_nxt = DONE;
               w_clear     = 1'b1;
               w_err_nxt   = 1'b1;
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign bus.cmd_gnt_o           = w_gnt;
   assign bus.busy_o              = (r_state != IDLE);
   assign bus.done_valid_o        = (r_state == DONE);
   assign bus.done_err_o          = (r_state == DONE) & r_err;
   assign bus.l1_sel_flush_addr_o = r_cmd.addr;
   assign bus.l2_sel_flush_addr_o = r_cmd.addr;

   assign bus.l1_flush_req_o     = (r_cmd.op == OP_W'(FLUSH))     ? w_l1_req : '0;
   assign bus.l1_sel_flush_req_o = (r_cmd.op == OP_W'(SEL_FLUSH)) ? w_l1_req : '0;
   assign bus.l2_flush_req_o     = (r_cmd.op == OP_W'(FLUSH))     ? w_l2_req : '0;
   assign bus.l2_sel_flush_req_o = (r_cmd.op == OP_W'(SEL_FLUSH)) ? w_l2_req : '0;
   assign bus.l2_enable_req_o    = (r_cmd.op == OP_W'(ENABLE))    ? w_l2_req : '0;
   assign bus.l2_disable_req_o   = (r_cmd.op == OP_W'(DISABLE))   ? w_l2_req : '0;
endmodule

// File: tb/tb_hier_icache_maint_seq.sv
// Directed self-checking bench for the icache maintenance sequencer.
module tb_hier_icache_maint_seq;
   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   logic       tie_l1, tie_l2;
   logic [8:0] m_l1_flush, m_l1_sel;
   logic [3:0] m_l2_flush, m_l2_sel, m_l2_en, m_l2_dis;

   hier_icache_maint_seq_if #(.NB_CORES(9), .NB_CACHE_BANKS(4)) bus ();

   hier_icache_maint_seq #(
      .NB_CORES       (9),
      .NB_CACHE_BANKS (4),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   assign bus.l1_flush_ack_i     = tie_l1 ? bus.l1_flush_req_o     : m_l1_flush;
   assign bus.l1_sel_flush_ack_i = tie_l1 ? bus.l1_sel_flush_req_o : m_l1_sel;
   assign bus.l2_flush_ack_i     = tie_l2 ? bus.l2_flush_req_o     : m_l2_flush;
   assign bus.l2_sel_flush_ack_i = tie_l2 ? bus.l2_sel_flush_req_o : m_l2_sel;
   assign bus.l2_enable_ack_i    = tie_l2 ? bus.l2_enable_req_o    : m_l2_en;
   assign bus.l2_disable_ack_i   = tie_l2 ? bus.l2_disable_req_o   : m_l2_dis;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs are then driven at +1 and outputs sampled at +2.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic any_req();
      return (|bus.l1_flush_req_o) | (|bus.l1_sel_flush_req_o) |
             (|bus.l2_flush_req_o) | (|bus.l2_sel_flush_req_o) |
             (|bus.l2_enable_req_o) | (|bus.l2_disable_req_o);
   endfunction

   task automatic issue(input logic [2:0] op, input logic [31:0] addr);
      bus.cmd_req_i  = 1'b1;
      bus.cmd_op_i   = op;
      bus.cmd_addr_i = addr;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      tie_l1 = 1'b1; tie_l2 = 1'b1;
      m_l1_flush = '0; m_l1_sel = '0;
      m_l2_flush = '0; m_l2_sel = '0; m_l2_en = '0; m_l2_dis = '0;
      bus.cmd_req_i = 1'b0; bus.cmd_op_i = '0; bus.cmd_addr_i = '0;
      repeat (3) tick();
      #1;
      chk("rst_busy", 32'(bus.busy_o), 32'd0);
      chk("rst_done", 32'(bus.done_valid_o), 32'd0);
      chk("rst_req",  32'(any_req()), 32'd0);
      chk("rst_addr", bus.l1_sel_flush_addr_o | bus.l2_sel_flush_addr_o, 32'd0);
      rst_n = 1'b1;

      // FLUSH with acks tied to requests: grant, L1, L2, done.
      tick();
      issue(3'd0, 32'h0);
      #1 chk("fl_gnt", 32'(bus.cmd_gnt_o), 32'd1);
      tick(); bus.cmd_req_i = 1'b0;
      #1 chk("fl_l1req", 32'(bus.l1_flush_req_o), 32'h1FF);
      chk("fl_l1_l2idle", 32'(bus.l2_flush_req_o), 32'h0);
      tick();
      #1 chk("fl_l2req", 32'(bus.l2_flush_req_o), 32'hF);
      chk("fl_l1off", 32'(bus.l1_flush_req_o), 32'h0);
      tick();
      #1 chk("fl_done", 32'(bus.done_valid_o), 32'd1);
      chk("fl_err", 32'(bus.done_err_o), 32'd0);
      tick();
      #1 chk("fl_idle", 32'(bus.busy_o), 32'd0);

      // ENABLE: L2 only, done two cycles after grant.
      issue(3'd2, 32'h0);
      #1 chk("en_gnt", 32'(bus.cmd_gnt_o), 32'd1);
      tick(); bus.cmd_req_i = 1'b0;
      #1 chk("en_l2req", 32'(bus.l2_enable_req_o), 32'hF);
      chk("en_nol1", 32'(bus.l1_flush_req_o | bus.l1_sel_flush_req_o), 32'h0);
      tick();
      #1 chk("en_done", 32'(bus.done_valid_o), 32'd1);
      tick();

      // SEL_FLUSH with staggered L1 acks.
      tie_l1 = 1'b0;
      issue(3'd1, 32'h1C00_8040);
      tick(); bus.cmd_req_i = 1'b0;
      #1 chk("sf_l1req0", 32'(bus.l1_sel_flush_req_o), 32'h1FF);
      tick(); m_l1_sel = 9'h001;
      #1 chk("sf_addr1", bus.l1_sel_flush_addr_o, 32'h1C00_8040);
      tick(); m_l1_sel = 9'h0FE;
      #1 chk("sf_l1req2", 32'(bus.l1_sel_flush_req_o), 32'h1FE);
      tick(); m_l1_sel = 9'h001;
      #1 chk("sf_l1req3", 32'(bus.l1_sel_flush_req_o), 32'h100);
      tick(); m_l1_sel = 9'h000;
      #1 chk("sf_l1req4", 32'(bus.l1_sel_flush_req_o), 32'h100);
      chk("sf_l2wait", 32'(bus.l2_sel_flush_req_o), 32'h0);
      tick(); m_l1_sel = 9'h100;
      #1 chk("sf_l1req5", 32'(bus.l1_sel_flush_req_o), 32'h100);
      tick(); m_l1_sel = 9'h000;
      #1 chk("sf_l2req", 32'(bus.l2_sel_flush_req_o), 32'hF);
      chk("sf_l1off", 32'(bus.l1_sel_flush_req_o), 32'h0);
      tick();
      #1 chk("sf_done", 32'(bus.done_valid_o), 32'd1);
      chk("sf_err", 32'(bus.done_err_o), 32'd0);
      chk("sf_addr2", bus.l2_sel_flush_addr_o, 32'h1C00_8040);
      tick();

      // DISABLE with bank 2 silent: timeout after 16 phase cycles.
      tie_l2 = 1'b0;
      m_l2_dis = 4'b1011;
      issue(3'd3, 32'h0);
      tick(); bus.cmd_req_i = 1'b0;
      #1 chk("ds_req0", 32'(bus.l2_disable_req_o), 32'hF);
      for (int i = 1; i < 16; i++) tick();
      #1 chk("ds_req15", 32'(bus.l2_disable_req_o), 32'h4);
      chk("ds_nodone", 32'(bus.done_valid_o), 32'd0);
      tick();
      #1 chk("ds_reqoff", 32'(bus.l2_disable_req_o), 32'h0);
      chk("ds_done", 32'(bus.done_valid_o), 32'd1);
      chk("ds_err", 32'(bus.done_err_o), 32'd1);
      tick(); m_l2_dis = '0; tie_l2 = 1'b1; tie_l1 = 1'b1;
      #1 chk("ds_idle", 32'(bus.busy_o), 32'd0);
      chk("ds_errclr", 32'(bus.done_err_o), 32'd0);

      // Illegal opcode 7.
      issue(3'd7, 32'h0);
      #1 chk("il_gnt", 32'(bus.cmd_gnt_o), 32'd1);
      tick(); bus.cmd_req_i = 1'b0;
      #1 chk("il_done", 32'(bus.done_valid_o), 32'd1);
      chk("il_err", 32'(bus.done_err_o), 32'd1);
      chk("il_noreq", 32'(any_req()), 32'd0);
      tick();
      #1 chk("il_idle", 32'(bus.busy_o), 32'd0);

      // Request held high across a busy FLUSH.
      issue(3'd0, 32'h0);
      #1 chk("hd_gnt0", 32'(bus.cmd_gnt_o), 32'd1);
      tick();
      #1 chk("hd_gnt1", 32'(bus.cmd_gnt_o), 32'd0);
      tick();
      #1 chk("hd_gnt2", 32'(bus.cmd_gnt_o), 32'd0);
      tick();
      #1 chk("hd_done", 32'(bus.done_valid_o), 32'd1);
      chk("hd_gnt3", 32'(bus.cmd_gnt_o), 32'd0);
      tick();
      #1 chk("hd_gnt4", 32'(bus.cmd_gnt_o), 32'd1);
      tick(); bus.cmd_req_i = 1'b0;
      repeat (3) tick();
      #1 chk("hd_idle", 32'(bus.busy_o), 32'd0);

      // Reset while L1 requests are outstanding.
      tie_l1 = 1'b0;
      issue(3'd1, 32'hDEAD_BEE0);
      tick(); bus.cmd_req_i = 1'b0;
      #1 chk("rs_l1req", 32'(bus.l1_sel_flush_req_o), 32'h1FF);
      rst_n = 1'b0;
      tick();
      #1 chk("rs_req", 32'(any_req()), 32'd0);
      chk("rs_busy", 32'(bus.busy_o), 32'd0);
      chk("rs_done", 32'(bus.done_valid_o), 32'd0);
      chk("rs_addr", bus.l1_sel_flush_addr_o, 32'h0);
      rst_n = 1'b1;
      tick();
      #1 chk("rs_done2", 32'(bus.done_valid_o), 32'd0);
      chk("rs_req2", 32'(any_req()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
